// File: rtl/control_unit_seq.sv
// Registered, multi-cycle ID-stage control unit: one opcode per valid/ready handshake, control word one cycle later.
// Build option CU_INTERRUPT_EN enables interrupt acceptance and RTI/INT sequencing; without it both decode as NOP.
module control_unit_seq #(
    parameter int OP_W   = 5,
    parameter int ALU_W  = 13,
    parameter int STEP_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [OP_W-1:0]   op_code,
    output logic              instr_ready,
    input  logic              stall,
    input  logic              flush,
    input  logic              int_req,
    output logic              int_ack,
    output logic              cs_valid,
    output logic [ALU_W-1:0]  alu_controls,
    output logic              cs_mem_read,
    output logic              cs_mem_write,
    output logic              cs_reg_write,
    output logic              cs_push,
    output logic              cs_pop,
    output logic              cs_ldm,
    output logic              cs_std,
    output logic              cs_jmp,
    output logic              cs_call,
    output logic              cs_ret,
    output logic              cs_rti,
    output logic              cs_int,
    output logic              cs_alu_op,
    output logic              cs_mem_op,
    output logic [STEP_W-1:0] seq_step,
    output logic              seq_last
);

    localparam logic [OP_W-1:0] OP_LDM  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_STD  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_NOT  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_PUSH = OP_W'(6);
    localparam logic [OP_W-1:0] OP_POP  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_CALL = OP_W'(8);
    localparam logic [OP_W-1:0] OP_RET  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_RTI  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_INT  = OP_W'(11);

    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(1) << 5;
    localparam logic [ALU_W-1:0] ALU_NOT = ALU_W'(1) << 9;
    localparam logic [ALU_W-1:0] ALU_NOP = ALU_W'(1) << 10;

    typedef enum logic {IDLE, SEQ} state_t;

    typedef struct packed {
        logic [ALU_W-1:0] alu;
        logic mem_read, mem_write, reg_write, push, pop, ldm, std;
        logic jmp, call, ret, rti, intr, alu_op, mem_op;
    } cw_t;

    // Control word for one micro-step of an opcode; NOP and every illegal code share the default arm.
    function automatic cw_t decode(input logic [OP_W-1:0] op, input logic [STEP_W-1:0] step);
        cw_t w;
        w = '0;
        case (op)
            OP_LDM:  begin w.ldm = 1'b1; w.reg_write = 1'b1; w.alu_op = 1'b1; end
            OP_STD:  begin w.std = 1'b1; w.mem_write = 1'b1; w.mem_op = 1'b1; end
            OP_ADD:  begin w.alu = ALU_ADD; w.reg_write = 1'b1; w.alu_op = 1'b1; end
            OP_NOT:  begin w.alu = ALU_NOT; w.reg_write = 1'b1; w.alu_op = 1'b1; end
            OP_PUSH: begin w.push = 1'b1; w.mem_write = 1'b1; w.mem_op = 1'b1; end
            OP_POP:  begin w.pop = 1'b1; w.mem_read = 1'b1; w.mem_op = 1'b1; w.reg_write = 1'b1; end
            OP_CALL: begin
                w.push = 1'b1; w.mem_write = 1'b1; w.call = 1'b1; w.mem_op = 1'b1;
                w.jmp  = (step == STEP_W'(1));
            end
            OP_RET:  begin
                w.pop = 1'b1; w.mem_read = 1'b1; w.ret = 1'b1; w.mem_op = 1'b1;
                w.jmp = (step == STEP_W'(1));
            end
`ifdef CU_INTERRUPT_EN
            OP_RTI:  begin
                w.pop = 1'b1; w.mem_read = 1'b1; w.rti = 1'b1; w.mem_op = 1'b1;
                w.jmp = (step == STEP_W'(2));
            end
            OP_INT:  begin
                w.push = 1'b1; w.mem_write = 1'b1; w.intr = 1'b1; w.mem_op = 1'b1;
                w.jmp  = (step == STEP_W'(2));
            end
`else
            OP_RTI, OP_INT: begin w.alu = ALU_NOP; w.alu_op = 1'b1; end
`endif
            default: begin w.alu = ALU_NOP; w.alu_op = 1'b1; end
        endcase
        return w;
    endfunction

    function automatic logic [STEP_W-1:0] last_idx(input logic [OP_W-1:0] op);
        case (op)
            OP_CALL, OP_RET: return STEP_W'(1);
`ifdef CU_INTERRUPT_EN
            OP_RTI, OP_INT:  return STEP_W'(2);
`endif
            default:         return '0;
        endcase
    endfunction

    state_t            state_q;
    logic [STEP_W-1:0] step_q, step_d;
    logic [OP_W-1:0]   op_q, op_sel_d;
    cw_t               word_q;
    logic              valid_q, last_q, int_ack_q;
    logic              int_take, accept, start;

`ifdef CU_INTERRUPT_EN
    assign int_take    = (state_q == IDLE) && !stall && !flush && int_req;
    assign instr_ready = (state_q == IDLE) && !stall && !flush && !int_req;
`else
    logic unused_int_req;
    assign unused_int_req = int_req;
    assign int_take       = 1'b0;
    assign instr_ready    = (state_q == IDLE) && !stall && !flush;
`endif

    assign accept   = instr_valid && instr_ready;
    assign start    = accept || int_take;
    assign op_sel_d = int_take ? OP_INT : op_code;
    assign step_d   = step_q + STEP_W'(1);

    // Issue stage: flush shares the reset path; stall freezes everything.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q   <= IDLE;
            step_q    <= '0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
            word_q    <= '0;
            int_ack_q <= 1'b0;
        end else if (!stall) begin
            int_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        word_q    <= decode(op_sel_d, '0);
                        valid_q   <= 1'b1;
                        step_q    <= '0;
                        last_q    <= (last_idx(op_sel_d) == '0);
                        state_q   <= (last_idx(op_sel_d) == '0) ? IDLE : SEQ;
                        int_ack_q <= int_take;
                    end else begin
                        word_q  <= '0;
                        valid_q <= 1'b0;
                        step_q  <= '0;
                        last_q  <= 1'b0;
                    end
                end
                SEQ: begin
                    word_q  <= decode(op_q, step_d);
                    valid_q <= 1'b1;
                    step_q  <= step_d;
                    last_q  <= (step_d == last_idx(op_q));
                    if (step_d == last_idx(op_q)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Opcode held for the remaining micro-steps of a sequence.
    always_ff @(posedge clk) begin
        if (start) op_q <= op_sel_d;
    end

    assign int_ack      = int_ack_q;
    assign cs_valid     = valid_q;
    assign alu_controls = word_q.alu;
    assign cs_mem_read  = word_q.mem_read;
    assign cs_mem_write = word_q.mem_write;
    assign cs_reg_write = word_q.reg_write;
    assign cs_push      = word_q.push;
    assign cs_pop       = word_q.pop;
    assign cs_ldm       = word_q.ldm;
    assign cs_std       = word_q.std;
    assign cs_jmp       = word_q.jmp;
    assign cs_call      = word_q.call;
    assign cs_ret       = word_q.ret;
    assign cs_rti       = word_q.rti;
    assign cs_int       = word_q.intr;
    assign cs_alu_op    = word_q.alu_op;
    assign cs_mem_op    = word_q.mem_op;
    assign seq_step     = step_q;
    assign seq_last     = last_q;

endmodule
